// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8-bit UART receive stage with valid/ready holding register (optional even parity: UART_RX_PARITY_EN)
module uart_receiver #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OS_W     = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t           state, next_state;
  logic             rx_sync1, rx, rx_prev;
  logic [DIV_W-1:0] div_cnt;
  logic [OS_W-1:0]  tick_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             deliver_q;
  logic             tick, bit_tick;
  logic             start_det, start_sample, data_sample, stop_sample;
  logic             par_bad;

  assign tick     = (div_cnt == DIV_LAST);
  assign bit_tick = tick && (tick_cnt == OS_LAST);

  // Two-flop synchronizer plus one delay flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync1 <= 1'b1;
      rx       <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= RxD;
      rx       <= rx_sync1;
      rx_prev  <= rx;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic and sample strobes; every sample falls at mid-bit
  always_comb begin
    next_state   = state;
    start_det    = 1'b0;
    start_sample = 1'b0;
    data_sample  = 1'b0;
    stop_sample  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx) begin
          start_det  = 1'b1;
          next_state = START;
        end
      end
      START: begin
        if (tick && tick_cnt == OS_HALF) begin
          start_sample = 1'b1;
          next_state   = rx ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          data_sample = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) next_state = PARITY;
`else
          if (bit_idx == 3'd7) next_state = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_tick) next_state = STOP;
      end
`endif
      STOP: begin
        if (bit_tick) begin
          stop_sample = 1'b1;
          next_state  = rx ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rx) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Baud tick divider and per-bit tick counter, both realigned to the start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      if (start_det || tick) div_cnt <= '0;
      else                   div_cnt <= div_cnt + DIV_W'(1);
      if (start_det || start_sample) tick_cnt <= '0;
      else if (tick)                 tick_cnt <= (tick_cnt == OS_LAST) ? '0 : tick_cnt + OS_W'(1);
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_acc;

  // Running even-parity check over data bits, resolved when the parity bit is sampled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc <= 1'b0;
      par_bad <= 1'b0;
    end else if (start_sample) begin
      par_acc <= 1'b0;
      par_bad <= 1'b0;
    end else if (data_sample) begin
      par_acc <= par_acc ^ rx;
    end else if (state == PARITY && bit_tick) begin
      par_bad <= par_acc ^ rx;
    end
  end

  // Parity error only reported when the stop bit itself is good
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= stop_sample && rx && par_bad;
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Shift register, bit index, frame error pulse and delivery request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift     <= '0;
      bit_idx   <= '0;
      frame_err <= 1'b0;
      deliver_q <= 1'b0;
    end else begin
      if (start_sample) bit_idx <= '0;
      if (data_sample) begin
        shift   <= {rx, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      frame_err <= stop_sample && !rx;
      deliver_q <= stop_sample && rx && !par_bad;
    end
  end

  // Holding register: deliver, handshake, and drop-with-overrun when still occupied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver_q) begin
        if (!valid || ready) begin
          data  <= shift;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
module tb_uart_receiver;

  localparam int CLK_FREQ = 100000000;
  localparam int BAUD     = 1562500;
  localparam int OS       = 16;
  localparam int BIT      = 64;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 676;
`else
  localparam int LAT = 612;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RxD = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int valid_cyc = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] rx_q[$];

  uart_receiver #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD),
    .OVERSAMPLE(OS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RxD       (RxD),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && ready) begin
        rx_q.push_back(data);
        valid_cyc = cyc;
      end
      if (frame_err)  ferr_cnt++;
      if (parity_err) perr_cnt++;
      if (overrun)    ovr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    rx_q.delete();
    ferr_cnt = 0;
    perr_cnt = 0;
    ovr_cnt  = 0;
  endtask

  function automatic logic [31:0] first_rx();
    if (rx_q.size() > 0) return {24'd0, rx_q[0]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic send_bit(input logic v);
    RxD = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic par, input logic stop, input int stop_len);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par) RxD = 1'b1;
`endif
    for (int i = 0; i < stop_len; i++) send_bit(stop);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  initial begin
    logic [7:0] b;

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", valid, 0);
    check("reset_data", data, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_parity_err", parity_err, 0);
    check("reset_overrun", overrun, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Clean frame with consumer ready
    clear_stats();
    b = 8'h55;
    send_byte(b, ^b, 1'b1, 1);
    check("t1_count", rx_q.size(), 1);
    check("t1_data", first_rx(), 32'h55);
    check("t1_latency", valid_cyc - start_cyc, LAT);
    check("t1_frame_err", ferr_cnt, 0);
    check("t1_overrun", ovr_cnt, 0);

    // Short low glitch must be rejected in START
    clear_stats();
    @(posedge clk);
    #1;
    RxD = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    RxD = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    #1;
    check("t2_glitch_count", rx_q.size(), 0);
    check("t2_glitch_ferr", ferr_cnt, 0);
    b = 8'hC9;
    send_byte(b, ^b, 1'b1, 1);
    check("t2_after_data", first_rx(), 32'hC9);

    // Bad stop bit, line held low, then a good frame
    clear_stats();
    b = 8'hA3;
    send_byte(b, ^b, 1'b0, 3);
    check("t3_frame_err", ferr_cnt, 1);
    check("t3_count", rx_q.size(), 0);
    check("t3_valid", valid, 0);
    clear_stats();
    b = 8'h3C;
    send_byte(b, ^b, 1'b1, 1);
    check("t3_next_data", first_rx(), 32'h3C);
    check("t3_next_ferr", ferr_cnt, 0);

    // Overrun while consumer stalled
    clear_stats();
    ready = 1'b0;
    b = 8'h12;
    send_byte(b, ^b, 1'b1, 1);
    b = 8'h34;
    send_byte(b, ^b, 1'b1, 1);
    check("t4_valid_held", valid, 1);
    check("t4_data_held", data, 32'h12);
    check("t4_overrun", ovr_cnt, 1);
    @(posedge clk);
    #1;
    ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_valid_cleared", valid, 0);
    check("t4_handshake_data", first_rx(), 32'h12);
    check("t4_handshake_count", rx_q.size(), 1);

    // Reset mid-frame, then a fresh frame
    clear_stats();
    fork
      begin
        b = 8'hF0;
        send_byte(b, ^b, 1'b1, 1);
      end
      begin
        repeat (5 * BIT + BIT / 2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_reset_valid", valid, 0);
        check("t5_reset_data", data, 0);
      end
    join
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    b = 8'h7E;
    send_byte(b, ^b, 1'b1, 1);
    check("t5_count", rx_q.size(), 1);
    check("t5_data", first_rx(), 32'h7E);

`ifdef UART_RX_PARITY_EN
    // Parity mismatch then matching parity
    clear_stats();
    send_byte(8'h07, 1'b0, 1'b1, 1);
    check("t6_parity_err", perr_cnt, 1);
    check("t6_bad_count", rx_q.size(), 0);
    clear_stats();
    send_byte(8'h07, 1'b1, 1'b1, 1);
    check("t6_good_data", first_rx(), 32'h07);
    check("t6_good_perr", perr_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
